// File: rtl/raven_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between two requesters,
// with a bounded burst length and a one-cycle registered read-valid strobe.
module raven_sram_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              pll_clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic              last_q;
  logic [3:0]        cnt_q;
  logic              rv0_q, rv1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic any_gnt;
  logic win;
  logic win_we;

  always_comb begin
    any_gnt = 1'b0;
    win     = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        any_gnt = 1'b1;
        // Stay with the owner only while its burst is still below the limit.
        win = ((cnt_q != 4'd0) && (cnt_q < MaxBurst)) ? last_q : ~last_q;
      end else if (m0_req) begin
        any_gnt = 1'b1;
        win     = 1'b0;
      end else if (m1_req) begin
        any_gnt = 1'b1;
        win     = 1'b1;
      end
    end
  end

  always_comb begin
    m0_gnt     = any_gnt & ~win;
    m1_gnt     = any_gnt & win;
    win_we     = win ? m1_we : m0_we;
    sram_csb   = ~any_gnt;
    sram_web   = ~(any_gnt & win_we);
    sram_addr  = any_gnt ? (win ? m1_addr : m0_addr) : addr_q;
    sram_wdata = any_gnt ? (win ? m1_wdata : m0_wdata) : wdata_q;
    m0_rdata   = sram_rdata;
    m1_rdata   = sram_rdata;
    // A reset cycle kills any read-valid left over from the previous cycle.
    m0_rvalid  = rv0_q & ~reset;
    m1_rvalid  = rv1_q & ~reset;
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rv0_q <= m0_gnt & ~m0_we;
      rv1_q <= m1_gnt & ~m1_we;
      if (any_gnt) begin
        addr_q  <= sram_addr;
        wdata_q <= sram_wdata;
        if ((win == last_q) && (cnt_q != 4'd0)) begin
          cnt_q <= (cnt_q < MaxBurst) ? cnt_q + 4'd1 : MaxBurst;
        end else begin
          cnt_q  <= 4'd1;
          last_q <= win;
        end
      end else begin
        cnt_q <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_raven_sram_arbiter.sv
// Directed and random checks of raven_sram_arbiter against a behavioural SRAM
// macro and a reference memory.
module tb_raven_sram_arbiter;

  localparam int unsigned MaxBurst = 4;

  logic        pll_clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_csb, sram_web;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic [31:0] sram_mem  [1024];
  logic [31:0] model_mem [1024];

  int errors = 0;
  int checks = 0;

  raven_sram_arbiter #(
    .ADDR_W   (10),
    .DATA_W   (32),
    .MAX_BURST(MaxBurst)
  ) dut (
    .pll_clk   (pll_clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial begin
    pll_clk = 1'b0;
    forever #5 pll_clk = ~pll_clk;
  end

  // Behavioural single-port macro: synchronous read, data held until next read.
  always @(posedge pll_clk) begin
    if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_addr] <= sram_wdata;
      else           sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic step();
    @(posedge pll_clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    m0_we  = 1'b1;
    m1_we  = 1'b1;
    step();
    #4;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
    end
    checks++;
    if ({sram_csb, sram_web} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ctl: got csb/web %b expected 11", {sram_csb, sram_web});
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
    #4;
    checks++;
    if ({m0_gnt, m1_gnt, sram_csb, sram_web} !== 4'b1000) begin
      errors++;
      $display("FAIL single_wr_ctl: got %b expected 1000", {m0_gnt, m1_gnt, sram_csb, sram_web});
    end
    checks++;
    if (sram_addr !== 10'h005 || sram_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_wr_cmd: got %h/%h expected 005/deadbeef", sram_addr, sram_wdata);
    end
    step();
    m0_we = 1'b0;
    #4;
    checks++;
    if ({m0_gnt, sram_csb, sram_web} !== 3'b101) begin
      errors++;
      $display("FAIL single_rd_ctl: got %b expected 101", {m0_gnt, sram_csb, sram_web});
    end
    step();
    m0_req = 1'b0;
    #4;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rdata: got %b/%h expected 1/deadbeef", m0_rvalid, m0_rdata);
    end
    checks++;
    if ({sram_csb, sram_web, m0_gnt} !== 3'b110 || sram_addr !== 10'h005) begin
      errors++;
      $display("FAIL single_idle: got %b addr %h expected 110 addr 005",
               {sram_csb, sram_web, m0_gnt}, sram_addr);
    end
    step();
    #4;
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid_pulse: got %b expected 0", m0_rvalid);
    end
    step();
  endtask

  task automatic test_first_tie();
    sram_mem[6] = 32'h12345678;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h005;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h006;
    #4;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL tie_first: got %b expected 10", {m0_gnt, m1_gnt});
    end
    step();
    m0_req = 1'b0;
    #4;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0110 || m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL tie_second: got %b data %h expected 0110 data deadbeef",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, m0_rdata);
    end
    step();
    m1_req = 1'b0;
    #4;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL tie_m1_rdata: got %b data %h expected 01 data 12345678",
               {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    step();
    #4;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL tie_rvalid_once: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
    step();
  endtask

  task automatic test_burst();
    logic [11:0] exp_seq;
    exp_seq = 12'b0000_1111_0000;  // bit i = expected winner in cycle i
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h001;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h002;
    for (int i = 0; i < 12; i++) begin
      #4;
      checks++;
      if ({m1_gnt, m0_gnt} !== (exp_seq[i] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL burst_cycle%0d: got m1/m0 gnt %b expected port %0d",
                 i, {m1_gnt, m0_gnt}, exp_seq[i]);
      end
      step();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h003;
    m1_we = 1'b0; m1_addr = 10'h004;
    for (int i = 0; i < 10; i++) begin
      #4;
      checks++;
      if (m0_gnt !== 1'b1) begin
        errors++;
        $display("FAIL sat_alone%0d: got m0_gnt %b expected 1", i, m0_gnt);
      end
      step();
    end
    m1_req = 1'b1;
    #4;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL sat_join: got %b expected 01", {m0_gnt, m1_gnt});
    end
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h006;
    #4;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt: got %b expected 1", m1_gnt);
    end
    step();
    reset  = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h005;
    #4;
    checks++;
    if ({m0_gnt, m1_gnt, m1_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_cycle: got gnt/rvalid %b expected 000", {m0_gnt, m1_gnt, m1_rvalid});
    end
    step();
    reset = 1'b0;
    #4;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_tie: got %b expected 10", {m0_gnt, m1_gnt});
    end
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_stress();
    logic        p0, p1, ev0, ev1, nv0, nv1;
    logic [31:0] ed0, ed1, nd0, nd1;
    int          w0, w1;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i]  = 32'h0;
      model_mem[i] = 32'h0;
    end
    p0 = 1'b0; p1 = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
    ed0 = '0; ed1 = '0; w0 = 0; w1 = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (!p0 && $urandom_range(0, 9) < 7) begin
        p0 = 1'b1; m0_we = 1'($urandom_range(0, 1));
        m0_addr = 10'($urandom_range(0, 15)); m0_wdata = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 7) begin
        p1 = 1'b1; m1_we = 1'($urandom_range(0, 1));
        m1_addr = 10'($urandom_range(0, 15)); m1_wdata = $urandom;
      end
      m0_req = p0;
      m1_req = p1;
      #4;
      checks++;
      if ((m0_gnt & m1_gnt) || (m0_gnt & ~p0) || (m1_gnt & ~p1) || ((p0 | p1) & ~(m0_gnt | m1_gnt))) begin
        errors++;
        $display("FAIL stress_gnt c%0d: got gnt %b expected one-hot for req %b",
                 c, {m0_gnt, m1_gnt}, {p0, p1});
      end
      checks++;
      if (m0_rvalid !== ev0 || (ev0 && m0_rdata !== ed0)) begin
        errors++;
        $display("FAIL stress_m0_read c%0d: got %b/%h expected %b/%h", c, m0_rvalid, m0_rdata, ev0, ed0);
      end
      checks++;
      if (m1_rvalid !== ev1 || (ev1 && m1_rdata !== ed1)) begin
        errors++;
        $display("FAIL stress_m1_read c%0d: got %b/%h expected %b/%h", c, m1_rvalid, m1_rdata, ev1, ed1);
      end
      nv0 = 1'b0; nv1 = 1'b0; nd0 = '0; nd1 = '0;
      if (m0_gnt) begin
        checks++;
        if (w0 > MaxBurst) begin
          errors++;
          $display("FAIL stress_m0_wait c%0d: got %0d cycles expected <= %0d", c, w0, MaxBurst);
        end
        if (m0_we) model_mem[m0_addr] = m0_wdata;
        else begin nv0 = 1'b1; nd0 = model_mem[m0_addr]; end
        w0 = 0; p0 = 1'b0;
      end else if (p0) w0++;
      if (m1_gnt) begin
        checks++;
        if (w1 > MaxBurst) begin
          errors++;
          $display("FAIL stress_m1_wait c%0d: got %0d cycles expected <= %0d", c, w1, MaxBurst);
        end
        if (m1_we) model_mem[m1_addr] = m1_wdata;
        else begin nv1 = 1'b1; nd1 = model_mem[m1_addr]; end
        w1 = 0; p1 = 1'b0;
      end else if (p1) w1++;
      ev0 = nv0; ed0 = nd0;
      ev1 = nv1; ed1 = nd1;
      step();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
    step();
    test_reset();
    test_single();
    test_first_tie();
    test_burst();
    test_saturation();
    test_reset_mid_read();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
